multi_key_counter: RTL and testbench

Parametrised, multi-channel successor to the single key-controlled up/down counter. Each channel owns an increment key and a decrement key (active-low push buttons), synchronises and debounces them internally, and steps a WIDTH-bit counter with selectable wrap or saturate behaviour. An optional auto-repeat mode steps the counter continuously while a key is held. It sits between the board `key_sw` pins and LED/seven-segment display logic in lab tops.

---
 rtl/multi_key_counter.sv | 152 +++++++++++++++
 tb/tb_multi_key_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_key_counter.sv
// Multi-channel key-driven up/down counter: per-key 2-FF sync + debounce, wrap or saturate stepping.
// Optional hold-to-repeat stepping is compiled in when KEY_AUTOREPEAT_EN is defined.
module multi_key_counter #(
  parameter int CHANNELS        = 2,
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SATURATE        = 0,
  parameter int REPEAT_DELAY    = 1024,
  parameter int REPEAT_PERIOD   = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       key_inc_n,
  input  logic [CHANNELS-1:0]       key_dec_n,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       limit
);

  localparam int KEYS = 2 * CHANNELS;
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("multi_key_counter: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // Returns {limit, next value} for a single step in the selected overflow mode.
  function automatic logic [WIDTH:0] step_val(input logic [WIDTH-1:0] v, input logic up);
    logic [WIDTH-1:0] max_v;
    max_v = '1;
    if (up) begin
      if (v == max_v) return {1'b1, (SATURATE != 0) ? max_v : WIDTH'(0)};
      return {1'b0, v + WIDTH'(1)};
    end
    if (v == WIDTH'(0)) return {1'b1, (SATURATE != 0) ? WIDTH'(0) : max_v};
    return {1'b0, v - WIDTH'(1)};
  endfunction

  logic [KEYS-1:0]  raw_keys;
  logic [KEYS-1:0]  sync1_q, sync2_q;
  logic [KEYS-1:0]  deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0]   dbc_q [KEYS];
  logic [DBW-1:0]   dbc_d [KEYS];
  logic [KEYS-1:0]  evt;
  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic [WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0] lim_q, lim_d;

  // Inc keys occupy the low half of every per-key vector, dec keys the high half.
  assign raw_keys = {key_dec_n, key_inc_n};

  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < KEYS; k++) begin
      dbc_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (dbc_q[k] == DBW'(DEBOUNCE_CYCLES - 1)) deb_d[k] = sync2_q[k];
        else                                      dbc_d[k] = dbc_q[k] + DBW'(1);
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0]   rpt_q [KEYS];
  logic [RW-1:0]   rpt_d [KEYS];
  logic [KEYS-1:0] rpt_rep_q, rpt_rep_d, rpt_fire;

  // rpt_q counts cycles since the press event; rpt_rep_q selects delay vs period target.
  always_comb begin
    rpt_rep_d = '0;
    rpt_fire  = '0;
    for (int k = 0; k < KEYS; k++) begin
      rpt_d[k] = '0;
      if (!deb_q[k] && !clear) begin
        if (rpt_q[k] == (rpt_rep_q[k] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
          rpt_fire[k]  = 1'b1;
          rpt_d[k]     = RW'(1);
          rpt_rep_d[k] = 1'b1;
        end else begin
          rpt_d[k]     = rpt_q[k] + RW'(1);
          rpt_rep_d[k] = rpt_rep_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_rep_q <= '0;
      for (int k = 0; k < KEYS; k++) rpt_q[k] <= '0;
    end else begin
      rpt_rep_q <= rpt_rep_d;
      for (int k = 0; k < KEYS; k++) rpt_q[k] <= rpt_d[k];
    end
  end

  assign evt = (deb_prev_q & ~deb_q) | rpt_fire;
`else
  assign evt = deb_prev_q & ~deb_q;
`endif

  always_comb begin
    lim_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      logic [WIDTH:0] r;
      r        = '0;
      cnt_d[c] = cnt_q[c];
      if (clear) begin
        cnt_d[c] = '0;
      end else if (evt[c] && !evt[CHANNELS+c]) begin
        r        = step_val(cnt_q[c], 1'b1);
        cnt_d[c] = r[WIDTH-1:0];
        lim_d[c] = r[WIDTH];
      end else if (evt[CHANNELS+c] && !evt[c]) begin
        r        = step_val(cnt_q[c], 1'b0);
        cnt_d[c] = r[WIDTH-1:0];
        lim_d[c] = r[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      lim_q      <= '0;
      for (int k = 0; k < KEYS; k++)     dbc_q[k] <= '0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      sync1_q    <= raw_keys;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      lim_q      <= lim_d;
      for (int k = 0; k < KEYS; k++)     dbc_q[k] <= dbc_d[k];
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  always_comb begin
    count = '0;
    for (int c = 0; c < CHANNELS; c++) count[c*WIDTH +: WIDTH] = cnt_q[c];
  end

  assign limit = lim_q;

endmodule

// File: tb/tb_multi_key_counter.sv
// Scoreboard bench for multi_key_counter: one wrap-mode and one saturate-mode instance.
module tb_multi_key_counter;

  localparam int D = 16;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic [1:0] lim;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] inc_w = 2'b11, dec_w = 2'b11, inc_s = 2'b11, dec_s = 2'b11;
  logic       clr_w = 1'b0, clr_s = 1'b0;
  logic [7:0] count_w, count_s;
  logic [1:0] limit_w, limit_s;
  logic [7:0] prev_w = '0, prev_s = '0;
  logic [3:0] mw [2];
  logic [3:0] ms [2];
  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  exp_t       q_w[$];
  exp_t       q_s[$];

  multi_key_counter #(.CHANNELS(2), .WIDTH(4), .DEBOUNCE_CYCLES(D), .SATURATE(0),
                      .REPEAT_DELAY(64), .REPEAT_PERIOD(16)) u_wrap (
    .clk(clk), .reset(reset), .key_inc_n(inc_w), .key_dec_n(dec_w),
    .clear(clr_w), .count(count_w), .limit(limit_w));

  multi_key_counter #(.CHANNELS(2), .WIDTH(4), .DEBOUNCE_CYCLES(D), .SATURATE(1),
                      .REPEAT_DELAY(64), .REPEAT_PERIOD(16)) u_sat (
    .clk(clk), .reset(reset), .key_inc_n(inc_s), .key_dec_n(dec_s),
    .clear(clr_s), .count(count_s), .limit(limit_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Event word: cycle | 0000 | count | limit, so hex dumps stay readable.
  function automatic logic [63:0] pk(input int c, input logic [7:0] cnt, input logic [1:0] lim);
    return {c[31:0], 16'h0, cnt, 6'h0, lim};
  endfunction

  function automatic logic [4:0] mstep(input logic [3:0] v, input bit up, input bit sat);
    if (up) begin
      if (v == 4'hF) return sat ? {1'b1, v} : 5'h10;
      return {1'b0, v + 4'h1};
    end
    if (v == 4'h0) return sat ? {1'b1, v} : 5'h1F;
    return {1'b0, v - 4'h1};
  endfunction

  always @(negedge clk) begin
    if (!reset && (count_w !== prev_w || limit_w !== 2'b00)) begin
      if (q_w.size() == 0) chk("wrap_unexpected_evt", pk(cyc, count_w, limit_w), 64'h0);
      else begin
        chk("wrap_evt", pk(cyc, count_w, limit_w), pk(q_w[0].cyc, q_w[0].cnt, q_w[0].lim));
        q_w.delete(0);
      end
    end
    prev_w <= count_w;
  end

  always @(negedge clk) begin
    if (!reset && (count_s !== prev_s || limit_s !== 2'b00)) begin
      if (q_s.size() == 0) chk("sat_unexpected_evt", pk(cyc, count_s, limit_s), 64'h0);
      else begin
        chk("sat_evt", pk(cyc, count_s, limit_s), pk(q_s[0].cyc, q_s[0].cnt, q_s[0].lim));
        q_s.delete(0);
      end
    end
    prev_s <= count_s;
  end

  task automatic apply(input bit s, input logic [1:0] im, input logic [1:0] dm,
                       input bit clr, input int at);
    logic [3:0] o [2];
    logic [3:0] n [2];
    logic [1:0] lv;
    logic [4:0] r;
    exp_t       e;
    lv = '0;
    for (int ch = 0; ch < 2; ch++) begin
      o[ch] = s ? ms[ch] : mw[ch];
      n[ch] = o[ch];
      if (clr) n[ch] = 4'h0;
      else if (im[ch] && !dm[ch]) begin
        r = mstep(o[ch], 1'b1, s); n[ch] = r[3:0]; lv[ch] = r[4];
      end else if (dm[ch] && !im[ch]) begin
        r = mstep(o[ch], 1'b0, s); n[ch] = r[3:0]; lv[ch] = r[4];
      end
    end
    if (n[0] != o[0] || n[1] != o[1] || lv != 2'b00) begin
      e.cyc = at; e.cnt = {n[1], n[0]}; e.lim = lv;
      if (s) q_s.push_back(e); else q_w.push_back(e);
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (s) ms[ch] = n[ch]; else mw[ch] = n[ch];
    end
  endtask

  task automatic drive(input bit s, input logic [1:0] im, input logic [1:0] dm);
    if (s) begin inc_s = ~im; dec_s = ~dm; end
    else   begin inc_w = ~im; dec_w = ~dm; end
  endtask

  task automatic set_clr(input bit s, input logic v);
    if (s) clr_s = v; else clr_w = v;
  endtask

  // Pin low for 'hold' cycles; press lands at c+D+3, repeats 64 then every 16 cycles later.
  task automatic press(input bit s, input logic [1:0] im, input logic [1:0] dm,
                       input int hold, input bit clr_evt);
    int c;
    int nrep;
    @(negedge clk);
    c = cyc;
    drive(s, im, dm);
    if (hold >= D) begin
      nrep = 0;
`ifdef KEY_AUTOREPEAT_EN
      for (int k = 64; k <= hold - 1; k += 16) nrep++;
`endif
      for (int r = 0; r <= nrep; r++)
        apply(s, im, dm, clr_evt && (r == 0), c + D + 3 + ((r == 0) ? 0 : 64 + 16 * (r - 1)));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (clr_evt) set_clr(s, cyc == c + D + 2);
    end
    drive(s, 2'b00, 2'b00);
    set_clr(s, 1'b0);
    repeat (30) @(negedge clk);
  endtask

  task automatic clr_pulse(input bit s);
    @(negedge clk);
    set_clr(s, 1'b1);
    apply(s, 2'b00, 2'b00, 1'b1, cyc + 1);
    @(negedge clk);
    set_clr(s, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin mw[ch] = 4'h0; ms[ch] = 4'h0; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_count_w", count_w, 8'h00);
    chk("reset_limit_w", limit_w, 2'b00);
    chk("reset_count_s", count_s, 8'h00);
    chk("reset_limit_s", limit_s, 2'b00);

    press(1'b0, 2'b01, 2'b00, 40, 1'b0);
    chk("first_press", count_w, 8'h01);
    press(1'b0, 2'b00, 2'b10, 10, 1'b0);
    chk("glitch_ignored", count_w, 8'h01);
    clr_pulse(1'b0);
    chk("clear_pulse", count_w, 8'h00);

    for (int i = 0; i < 15; i++) press(1'b0, 2'b01, 2'b00, 20, 1'b0);
    chk("wrap_at_15", count_w, 8'h0F);
    press(1'b0, 2'b01, 2'b00, 20, 1'b0);
    chk("wrap_to_0", count_w, 8'h00);
    press(1'b0, 2'b00, 2'b01, 20, 1'b0);
    chk("wrap_dec_to_15", count_w, 8'h0F);
    press(1'b0, 2'b11, 2'b00, 20, 1'b0);
    chk("two_channels", count_w, 8'h10);
    press(1'b0, 2'b01, 2'b00, 200, 1'b0);
`ifdef KEY_AUTOREPEAT_EN
    chk("hold_200", count_w, 8'h1A);
`else
    chk("hold_200", count_w, 8'h11);
`endif

    press(1'b1, 2'b00, 2'b01, 20, 1'b0);
    chk("sat_dec_at_0", count_s, 8'h00);
    for (int i = 0; i < 15; i++) press(1'b1, 2'b10, 2'b00, 20, 1'b0);
    chk("sat_ch1_15", count_s, 8'hF0);
    press(1'b1, 2'b10, 2'b00, 20, 1'b0);
    chk("sat_inc_at_max", count_s, 8'hF0);
    for (int i = 0; i < 5; i++) press(1'b1, 2'b01, 2'b00, 20, 1'b0);
    chk("sat_ch0_5", count_s, 8'hF5);
    press(1'b1, 2'b01, 2'b00, 20, 1'b1);
    chk("clear_beats_inc", count_s, 8'h00);
    for (int i = 0; i < 7; i++) press(1'b1, 2'b01, 2'b00, 20, 1'b0);
    press(1'b1, 2'b01, 2'b01, 20, 1'b0);
    chk("inc_dec_together", count_s, 8'h07);

    for (int i = 0; i < 100 && (q_w.size() != 0 || q_s.size() != 0); i++) @(negedge clk);
    chk("wrap_events_left", q_w.size(), 0);
    chk("sat_events_left", q_s.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
